// File: rtl/mem_dump.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dump
//  Purpose  : Debug read-out engine. On a start pulse it walks data memory
//             from address 0 to DEPTH-1 through the memory's own read port,
//             captures each registered read word and streams it to a UART
//             transmitter low byte first, one byte per start/done handshake.
//  Ports    : clk, rst_n        - clock, synchronous active-low reset
//             start             - dump request, honoured only when idle
//             RdRam/WrRam/Addr  - data memory control (WrRam tied low)
//             Mem_Data          - data memory registered read output
//             tx_data/tx_start  - byte and one-cycle start pulse to UART TX
//             tx_done           - one-cycle byte-finished tick from UART TX
//             busy/done         - engine active / one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module mem_dump #(
    parameter int AB    = 11,
    parameter int DB    = 16,
    parameter int DEPTH = 2048
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          RdRam,
    output logic          WrRam,
    output logic [AB-1:0] Addr,
    input  logic [DB-1:0] Mem_Data,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_done,
    output logic          busy,
    output logic          done
);

    localparam int              c_NB       = DB / 8;
    localparam int              c_BIW      = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam logic [AB-1:0]   c_LAST_PTR = AB'(DEPTH - 1);
    localparam logic [c_BIW-1:0] c_LAST_BI = c_BIW'(c_NB - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_LATCH   = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_TX = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [AB-1:0]               r_ptr;
    logic [c_BIW-1:0]            r_bi;
    logic [c_NB-1:0][7:0]        r_wr;     // captured word viewed as bytes
    logic [7:0]                  r_tx_data;
    logic [c_BIW-1:0]            w_bi_inc;

    assign w_bi_inc = r_bi + c_BIW'(1);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_READ;
            S_READ:    w_next = S_LATCH;
            S_LATCH:   w_next = S_SEND;
            S_SEND:    w_next = S_WAIT_TX;
            S_WAIT_TX: begin
                if (tx_done) begin
                    if (r_bi != c_LAST_BI)       w_next = S_SEND;
                    else if (r_ptr == c_LAST_PTR) w_next = S_FIN;
                    else                          w_next = S_READ;
                end
            end
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_bi      <= '0;
            r_wr      <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) r_ptr <= '0;
                end
                S_LATCH: begin
                    // The read issued from READ is valid on Mem_Data now.
                    // tx_data is preloaded so it is already valid in SEND.
                    r_wr      <= Mem_Data;
                    r_bi      <= '0;
                    r_tx_data <= Mem_Data[7:0];
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        if (r_bi != c_LAST_BI) begin
                            r_bi      <= w_bi_inc;
                            r_tx_data <= r_wr[w_bi_inc];
                        end else if (r_ptr != c_LAST_PTR) begin
                            // The last word is never followed by an increment,
                            // so Addr stays at DEPTH-1 and never wraps.
                            r_ptr <= r_ptr + AB'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign RdRam    = (r_state == S_READ);
    assign WrRam    = 1'b0;
    assign Addr     = r_ptr;
    assign tx_data  = r_tx_data;
    assign tx_start = (r_state == S_SEND);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FIN);

endmodule
`default_nettype wire
